// File: rtl/uart_tx.sv
// UART transmitter: takes a byte over valid/ready and shifts it out LSB-first as
// start, data, optional parity and stop bits, one bit per rising edge of UART_clk.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 UART_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // DATA_BITS >= 5 always exceeds STOP_BITS, so one counter serves both phases.
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  state_t               r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
  logic                 r_par,   w_par_nxt;
  logic                 r_tx,    w_tx_nxt;
  logic                 r_done,  w_done_nxt;
  logic                 r_uart_clk_q;
  logic                 w_tick;

  // Delay register resets high so a UART_clk already high at reset release is not a tick.
  assign w_tick = UART_clk & ~r_uart_clk_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_uart_clk_q <= 1'b1;
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_tx         <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_uart_clk_q <= UART_clk;
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_par        <= w_par_nxt;
      r_tx         <= w_tx_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_valid) begin
          w_shift_nxt = tx_data;
          w_par_nxt   = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          w_state_nxt = S_SYNC;
        end
      end
      S_SYNC: if (w_tick) begin
        w_state_nxt = S_START;
        w_tx_nxt    = 1'b0;
      end
      S_START: if (w_tick) begin
        w_state_nxt = S_DATA;
        w_tx_nxt    = r_shift[0];
        w_cnt_nxt   = '0;
      end
      S_DATA: if (w_tick) begin
        if (r_cnt != LAST_DATA) begin
          w_shift_nxt = r_shift >> 1;
          w_tx_nxt    = r_shift[1];
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end else if (PARITY_EN != 0) begin
          w_state_nxt = S_PARITY;
          w_tx_nxt    = r_par;
        end else begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_PARITY: if (w_tick) begin
        w_state_nxt = S_STOP;
        w_tx_nxt    = 1'b1;
        w_cnt_nxt   = '0;
      end
      S_STOP: if (w_tick) begin
        if (r_cnt != LAST_STOP) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == S_IDLE);
  assign tx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations (8N1, 8E2, 8O1) driven from a bench-side
// baud source, each frame checked sample-by-sample against a frame built from the data.
module tb_uart_tx;

  localparam int NCO_INC = 37;

  logic clk = 1'b0;
  always #12 clk = ~clk;

  logic            rst = 1'b1;
  logic            uart_clk = 1'b1;
  logic [2:0][7:0] tx_data_i;
  logic [2:0]      tx_valid_i;
  logic [2:0]      tx_ready_o, tx_o, tx_busy_o, tx_done_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Baud source: 0 = hold a level, 1 = square wave of 2*half clk cycles, 2 = 8-bit NCO.
  int         baud_mode  = 0;
  logic       hold_level = 1'b1;
  int         half       = 3;
  int         half_cnt   = 0;
  logic [7:0] nco        = '0;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .UART_clk(uart_clk), .tx_data(tx_data_i[0]), .tx_valid(tx_valid_i[0]),
    .tx_ready(tx_ready_o[0]), .tx(tx_o[0]), .tx_busy(tx_busy_o[0]), .tx_done(tx_done_o[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst), .UART_clk(uart_clk), .tx_data(tx_data_i[1]), .tx_valid(tx_valid_i[1]),
    .tx_ready(tx_ready_o[1]), .tx(tx_o[1]), .tx_busy(tx_busy_o[1]), .tx_done(tx_done_o[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .UART_clk(uart_clk), .tx_data(tx_data_i[2]), .tx_valid(tx_valid_i[2]),
    .tx_ready(tx_ready_o[2]), .tx(tx_o[2]), .tx_busy(tx_busy_o[2]), .tx_done(tx_done_o[2]));

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (baud_mode)
      0: uart_clk = hold_level;
      1: begin
        half_cnt++;
        if (half_cnt >= half) begin
          half_cnt = 0;
          uart_clk = ~uart_clk;
        end
      end
      default: begin
        nco      = nco + 8'(NCO_INC);
        uart_clk = nco[7];
      end
    endcase
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference frame: start 0, data LSB-first, optional parity making the ones-count
  // even (or odd), then the stop bits as 1s.
  function automatic void build_frame(input int idx, input logic [7:0] d,
                                      output logic [11:0] fr, output int nb);
    int ones;
    bit pe, po;
    int ns;
    pe   = (idx != 0);
    po   = (idx == 2);
    ns   = (idx == 1) ? 2 : 1;
    fr   = '1;
    fr[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      fr[1 + i] = d[i];
      ones += int'(d[i]);
    end
    nb = 9;
    if (pe) begin
      fr[nb] = ((ones % 2) == 1) ^ po;
      nb++;
    end
    nb += ns;
  endfunction

  task automatic send(input int idx, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    tx_data_i[idx]  = d;
    tx_valid_i[idx] = 1'b1;
    while (tx_ready_o[idx] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (tx_ready_o[idx] !== 1'b1) begin
      n_err++;
      $display("FAIL send%0d ready: tx_ready=%b expected 1", idx, tx_ready_o[idx]);
    end
    @(posedge clk);
    #1;
    tx_valid_i[idx] = 1'b0;
    tx_data_i[idx]  = ~d;
  endtask

  task automatic wait_start(input int idx, input int limit, output logic found);
    found = 1'b0;
    for (int w = 0; w < limit && !found; w++) begin
      @(negedge clk);
      if (tx_o[idx] === 1'b0) found = 1'b1;
    end
  endtask

  task automatic check_frame(input int idx, input logic [7:0] d, input int p, input string tag,
                             output int t_start, output int t_done);
    logic [11:0] fr;
    int          nb;
    logic        found, ok, got;
    int          done_seen;
    build_frame(idx, d, fr, nb);
    t_start = -1;
    t_done  = -1;
    wait_start(idx, 6 * p + 20, found);
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s start: tx=%b, no start bit within %0d cycles", tag, tx_o[idx], 6 * p + 20);
      return;
    end
    t_start   = cyc;
    done_seen = 0;
    for (int i = 0; i < nb; i++) begin
      ok  = 1'b1;
      got = fr[i];
      for (int k = 0; k < p; k++) begin
        if (i > 0 || k > 0) @(negedge clk);
        if (tx_o[idx] !== fr[i]) begin
          ok  = 1'b0;
          got = tx_o[idx];
        end
        if (tx_done_o[idx] !== 1'b0) done_seen++;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s bit%0d: tx=%b expected %b", tag, i, got, fr[i]);
      end
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL %s early_done: tx_done high %0d cycles inside frame, expected 0", tag, done_seen);
    end
    @(negedge clk);
    t_done = cyc;
    n_cmp++;
    if ({tx_done_o[idx], tx_ready_o[idx], tx_o[idx]} !== 3'b111) begin
      n_err++;
      $display("FAIL %s frame_end: done/ready/tx=%b%b%b expected 111", tag,
               tx_done_o[idx], tx_ready_o[idx], tx_o[idx]);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_done_o[idx] !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_width: tx_done=%b expected 0", tag, tx_done_o[idx]);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    int ts, td, bad;
    baud_mode  = 0;
    hold_level = 1'b1;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_o, tx_ready_o} !== 6'b111111) begin
      n_err++;
      $display("FAIL reset_tx_ready: tx=%b ready=%b expected 111/111", tx_o, tx_ready_o);
    end
    n_cmp++;
    if ({tx_busy_o, tx_done_o} !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_busy_done: busy=%b done=%b expected 000/000", tx_busy_o, tx_done_o);
    end
    rst = 1'b0;
    d   = 8'($urandom);
    send(0, d);
    n_cmp++;
    if (tx_busy_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_accept: tx_busy=%b expected 1", tx_busy_o[0]);
    end
    // With UART_clk stuck high there is no tick, so the line must stay idle.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1 || tx_busy_o[0] !== 1'b1 || tx_done_o[0] !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_no_tick: %0d bad cycles, expected 0", bad);
    end
    half      = 3;
    half_cnt  = 0;
    baud_mode = 1;
    check_frame(0, d, 6, "after_hold", ts, td);
  endtask

  task automatic test_8n1();
    logic [7:0] d;
    int ts, td;
    half = 3;
    send(0, 8'hA5);
    check_frame(0, 8'hA5, 6, "8n1_a5", ts, td);
    for (int r = 0; r < 4; r++) begin
      half = int'($urandom_range(2, 5));
      d    = 8'($urandom);
      send(0, d);
      check_frame(0, d, 2 * half, "8n1_rand", ts, td);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    int ts, td;
    half = 3;
    for (int idx = 1; idx <= 2; idx++) begin
      send(idx, 8'h07);
      check_frame(idx, 8'h07, 6, (idx == 1) ? "8e2_07" : "8o1_07", ts, td);
      for (int r = 0; r < 2; r++) begin
        d = 8'($urandom);
        send(idx, d);
        check_frame(idx, d, 6, (idx == 1) ? "8e2_rand" : "8o1_rand", ts, td);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ts1, td1, ts2, td2, bad;
    half = 2;
    @(negedge clk);
    tx_data_i[0]  = 8'h3C;
    tx_valid_i[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_data_i[0] = 8'hC3;
    check_frame(0, 8'h3C, 4, "b2b_first", ts1, td1);
    tx_valid_i[0] = 1'b0;
    n_cmp++;
    if (tx_busy_o[0] !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: tx_busy=%b expected 1", tx_busy_o[0]);
    end
    check_frame(0, 8'hC3, 4, "b2b_second", ts2, td2);
    n_cmp++;
    if (ts2 - td1 != 4) begin
      n_err++;
      $display("FAIL b2b_gap: idle gap %0d cycles expected 4", ts2 - td1);
    end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_busy_o[0] !== 1'b0 || tx_o[0] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_no_third: %0d busy cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic found;
    int ts, td, bad;
    half = 3;
    d    = 8'($urandom) & 8'hF7;
    send(0, d);
    wait_start(0, 40, found);
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_start: tx=%b, no start bit", tx_o[0]);
    end
    repeat (4 * 6 + 3) @(negedge clk);
    n_cmp++;
    if (tx_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_bit3: tx=%b expected 0", tx_o[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({tx_o[0], tx_busy_o[0], tx_ready_o[0], tx_done_o[0]} !== 4'b1010) begin
      n_err++;
      $display("FAIL mid_reset: tx/busy/ready/done=%b%b%b%b expected 1010",
               tx_o[0], tx_busy_o[0], tx_ready_o[0], tx_done_o[0]);
    end
    rst = 1'b0;
    bad = 0;
    repeat (24) begin
      @(negedge clk);
      if (tx_done_o[0] !== 1'b0 || tx_o[0] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL mid_abort: %0d cycles with done or tx low, expected 0", bad);
    end
    d = 8'($urandom);
    send(0, d);
    check_frame(0, d, 6, "after_mid_reset", ts, td);
  endtask

  task automatic test_nco();
    logic [11:0] fr;
    int          nb, dur, w;
    logic        found, cur, done_seen;
    build_frame(0, 8'h55, fr, nb);
    baud_mode = 2;
    send(0, 8'h55);
    wait_start(0, 40, found);
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL nco_start: tx=%b, no start bit", tx_o[0]);
    end
    // 0x55 alternates every bit through bit 8, so each edge-to-edge span is one bit.
    for (int i = 0; i < 9; i++) begin
      cur = tx_o[0];
      dur = 0;
      while (tx_o[0] === cur && dur < 30) begin
        @(negedge clk);
        dur++;
      end
      n_cmp++;
      if (cur !== fr[i] || dur * NCO_INC < 256 - NCO_INC || dur * NCO_INC > 256 + NCO_INC) begin
        n_err++;
        $display("FAIL nco_bit%0d: level=%b len=%0d expected level %b len 256/%0d +-1",
                 i, cur, dur, fr[i], NCO_INC);
      end
    end
    done_seen = 1'b0;
    for (w = 0; w < 30 && !done_seen; w++) begin
      @(negedge clk);
      if (tx_done_o[0] === 1'b1) done_seen = 1'b1;
    end
    n_cmp++;
    if (!done_seen) begin
      n_err++;
      $display("FAIL nco_done: tx_done=%b, no pulse within 30 cycles", tx_done_o[0]);
    end
    baud_mode = 1;
  endtask

  initial begin
    tx_data_i  = '0;
    tx_valid_i = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    test_nco();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
